// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port, variable-latency memory between the IF fetch and MEM data ports.
// Defining MEMARB_FETCH_BUF_EN adds a one-entry fetch buffer that lets repeated fetches skip memory.
module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              dm_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              err_o,
    output logic [1:0]        dbg_state
);

    // Handshake: a port raises req and holds it (address/data stable) until its one-cycle ack;
    // in the ack cycle the request is ignored so it cannot be granted twice. The memory side holds
    // mem_req_o and all mem_* fields until the cycle mem_ready_i is seen high.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_ACC = 2'd1,
        DM_ACC = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);
    localparam logic [DATA_W-1:0] ABORT_WORD = DATA_W'(32'hDEAD_BEEF);

    state_t            state, state_next;
    logic              last_dm;
    logic [7:0]        wait_cnt;
    logic              if_elig, dm_elig, grant_if, grant_dm;
    logic              fetch_hit;
    logic [DATA_W-1:0] fetch_hit_data;

    assign if_stall_o = if_req_i & ~if_ack_o;
    assign dm_stall_o = dm_req_i & ~dm_ack_o;
    assign dbg_state  = state;

    assign if_elig  = if_req_i & ~if_ack_o;
    assign dm_elig  = dm_req_i & ~dm_ack_o;
    // On a tie the port that did not win last time goes first.
    assign grant_dm = dm_elig & (~if_elig | ~last_dm);
    assign grant_if = if_elig & ~grant_dm;

`ifdef MEMARB_FETCH_BUF_EN
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;

    assign fetch_hit      = buf_valid && (buf_addr == if_addr_i);
    assign fetch_hit_data = buf_data;
`else
    assign fetch_hit      = 1'b0;
    assign fetch_hit_data = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (grant_dm)                     state_next = DM_ACC;
                else if (grant_if && !fetch_hit)  state_next = IF_ACC;
            end
            IF_ACC, DM_ACC: begin
                if (mem_ready_i || (wait_cnt == WAIT_LIM)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            if_rdata_o  <= '0;
            if_ack_o    <= 1'b0;
            dm_rdata_o  <= '0;
            dm_ack_o    <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            err_o       <= 1'b0;
            last_dm     <= 1'b0;
            wait_cnt    <= '0;
`ifdef MEMARB_FETCH_BUF_EN
            buf_valid   <= 1'b0;
            buf_addr    <= '0;
            buf_data    <= '0;
`endif
        end else begin
            if_ack_o <= 1'b0;
            dm_ack_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_dm) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dm_we_i;
                        mem_addr_o  <= dm_addr_i;
                        mem_wdata_o <= dm_wdata_i;
                        wait_cnt    <= '0;
`ifdef MEMARB_FETCH_BUF_EN
                        if (dm_we_i) buf_valid <= 1'b0;
`endif
                    end else if (grant_if) begin
                        if (fetch_hit) begin
                            if_ack_o   <= 1'b1;
                            if_rdata_o <= fetch_hit_data;
                            last_dm    <= 1'b0;
                        end else begin
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= 1'b0;
                            mem_addr_o  <= if_addr_i;
                            mem_wdata_o <= '0;
                            wait_cnt    <= '0;
                        end
                    end
                end
                IF_ACC: begin
                    if (mem_ready_i) begin
                        mem_req_o  <= 1'b0;
                        if_rdata_o <= mem_rdata_i;
                        if_ack_o   <= 1'b1;
                        last_dm    <= 1'b0;
`ifdef MEMARB_FETCH_BUF_EN
                        buf_valid  <= 1'b1;
                        buf_addr   <= mem_addr_o;
                        buf_data   <= mem_rdata_i;
`endif
                    end else if (wait_cnt == WAIT_LIM) begin
                        mem_req_o  <= 1'b0;
                        if_rdata_o <= ABORT_WORD;
                        if_ack_o   <= 1'b1;
                        err_o      <= 1'b1;
`ifdef MEMARB_FETCH_BUF_EN
                        buf_valid  <= 1'b0;
`endif
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DM_ACC: begin
                    // An aborted write leaves memory untouched, so nothing further to undo here.
                    if (mem_ready_i) begin
                        mem_req_o  <= 1'b0;
                        dm_rdata_o <= mem_we_o ? '0 : mem_rdata_i;
                        dm_ack_o   <= 1'b1;
                        last_dm    <= 1'b1;
                    end else if (wait_cnt == WAIT_LIM) begin
                        mem_req_o  <= 1'b0;
                        dm_rdata_o <= ABORT_WORD;
                        dm_ack_o   <= 1'b1;
                        err_o      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed and randomized transactions against a transaction-level model
// with a behavioural memory responder. Tracks the fetch buffer when MEMARB_FETCH_BUF_EN is defined.
module tb_mem_arbiter;

    localparam int MAX_WAIT = 15;
    localparam int NEVER    = 200;
`ifdef MEMARB_FETCH_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic        clk, rst_i;
    logic        if_req_i, if_ack_o, if_stall_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        dm_req_i, dm_we_i, dm_ack_o, dm_stall_o;
    logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
    logic        mem_req_o, mem_we_o, mem_ready_i, err_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [1:0]  dbg_state;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
        .if_ack_o(if_ack_o), .if_stall_o(if_stall_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
        .dm_wdata_i(dm_wdata_i), .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
        .dm_stall_o(dm_stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
        .err_o(err_o), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    int          wait_q[$];
    logic [31:0] phys_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];
    bit          last_dm_m, buf_v, err_m;
    logic [31:0] buf_a, buf_d, last_if_rd, last_dm_rd;
    int          err_c;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h3C5A, ~a[15:0]};
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // Memory responder: pops the wait count for each new access, answers after that many cycles.
    int resp_cnt, resp_wait;
    bit resp_busy;
    always @(negedge clk) begin
        if (!mem_req_o) begin
            mem_ready_i = 1'b0;
            resp_busy   = 1'b0;
            resp_cnt    = 0;
        end else begin
            if (!resp_busy) begin
                resp_busy = 1'b1;
                resp_cnt  = 0;
                resp_wait = (wait_q.size() > 0) ? wait_q.pop_front() : NEVER;
            end
            if (resp_cnt == resp_wait) begin
                mem_ready_i = 1'b1;
                if (mem_we_o) begin
                    phys_mem[mem_addr_o] = mem_wdata_o;
                    mem_rdata_i = $urandom;
                end else begin
                    mem_rdata_i = phys_mem.exists(mem_addr_o) ? phys_mem[mem_addr_o] : init_word(mem_addr_o);
                end
            end else begin
                mem_ready_i = 1'b0;
                mem_rdata_i = $urandom;
                resp_cnt++;
            end
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Transaction-level model of one grant at cycle g: returns ack cycle, whether memory is used.
    task automatic model_port(input bit is_if, input logic [31:0] a, input bit we,
                              input logic [31:0] wd, input int w, input int g,
                              output int ackc, output bit acc);
        logic [31:0] d;
        if (is_if && buf_v && buf_a == a) begin
            acc = 1'b0;
            ackc = g + 1;
            d = buf_d;
            last_dm_m = 1'b0;
        end else begin
            acc = 1'b1;
            if (!is_if && we) buf_v = 1'b0;
            wait_q.push_back(w);
            if (w > MAX_WAIT) begin
                ackc = g + 2 + MAX_WAIT;
                d = 32'hDEAD_BEEF;
                if (err_c < 0) err_c = ackc;
                if (is_if) buf_v = 1'b0;
            end else begin
                ackc = g + 2 + w;
                if (we) begin
                    ref_mem[a] = wd;
                    d = 32'h0;
                end else begin
                    d = ref_rd(a);
                end
                if (is_if) begin
                    buf_v = BUF_EN;
                    buf_a = a;
                    buf_d = d;
                    last_dm_m = 1'b0;
                end else begin
                    last_dm_m = 1'b1;
                end
            end
        end
        exp_q.push_back(d);
        if (is_if) last_if_rd = d;
        else       last_dm_rd = d;
    endtask

    task automatic run_scenario(input bit do_if, input logic [31:0] ia, input int iw,
                                input bit do_dm, input bit dwe, input logic [31:0] da,
                                input logic [31:0] dd, input int dw);
        int if_g, dm_g, if_a, dm_a, last_c;
        bit if_acc, dm_acc;
        if_g = -10; dm_g = -10; if_a = -10; dm_a = -10;
        if_acc = 1'b0; dm_acc = 1'b0; err_c = -1;
        step();
        check("ack_idle_if", if_ack_o, 1'b0);
        check("ack_idle_dm", dm_ack_o, 1'b0);
        check("hold_if_rdata", if_rdata_o, last_if_rd);
        check("hold_dm_rdata", dm_rdata_o, last_dm_rd);
        if (do_if && do_dm && !last_dm_m) begin
            dm_g = 0;
            model_port(1'b0, da, dwe, dd, dw, dm_g, dm_a, dm_acc);
            if_g = dm_a;
            model_port(1'b1, ia, 1'b0, 32'h0, iw, if_g, if_a, if_acc);
        end else begin
            if (do_if) begin
                if_g = 0;
                model_port(1'b1, ia, 1'b0, 32'h0, iw, if_g, if_a, if_acc);
            end
            if (do_dm) begin
                dm_g = do_if ? if_a : 0;
                model_port(1'b0, da, dwe, dd, dw, dm_g, dm_a, dm_acc);
            end
        end
        if_req_i = do_if; if_addr_i = ia;
        dm_req_i = do_dm; dm_we_i = dwe; dm_addr_i = da; dm_wdata_i = dd;
        last_c = (if_a > dm_a) ? if_a : dm_a;
        for (int c = 1; c <= last_c; c++) begin
            step();
            if (c == err_c) err_m = 1'b1;
            check("if_ack", if_ack_o, do_if && c == if_a);
            check("dm_ack", dm_ack_o, do_dm && c == dm_a);
            check("if_stall", if_stall_o, if_req_i && c != if_a);
            check("dm_stall", dm_stall_o, dm_req_i && c != dm_a);
            check("err", err_o, err_m);
            if (do_if && c == if_g + 1) begin
                check("if_mem_req", mem_req_o, if_acc);
                if (if_acc) begin
                    check("if_mem_addr", mem_addr_o, ia);
                    check("if_mem_we", mem_we_o, 1'b0);
                end
            end
            if (do_dm && c == dm_g + 1) begin
                check("dm_mem_req", mem_req_o, 1'b1);
                check("dm_mem_addr", mem_addr_o, da);
                check("dm_mem_we", mem_we_o, dwe);
                if (dwe) check("dm_mem_wdata", mem_wdata_o, dd);
            end
            if (do_if && c == if_a) begin
                check("if_rdata", if_rdata_o, exp_q.pop_front());
                if_req_i = 1'b0;
            end
            if (do_dm && c == dm_a) begin
                check("dm_rdata", dm_rdata_o, exp_q.pop_front());
                dm_req_i = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        last_dm_m = 1'b0; buf_v = 1'b0; err_m = 1'b0;
        last_if_rd = 32'h0; last_dm_rd = 32'h0;
        exp_q.delete();
        wait_q.delete();
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(0, 7)) << 2;
    endfunction

    function automatic int rnd_wait();
        return ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        rst_i = 1'b0;
        if_req_i = 1'b0; if_addr_i = '0;
        dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
        mem_ready_i = 1'b0; mem_rdata_i = '0;
        model_reset();

        // Reset state: every output low while reset held and ports idle
        repeat (3) step();
        check("rst_if_ack", if_ack_o, 1'b0);
        check("rst_dm_ack", dm_ack_o, 1'b0);
        check("rst_if_rdata", if_rdata_o, 32'h0);
        check("rst_dm_rdata", dm_rdata_o, 32'h0);
        check("rst_if_stall", if_stall_o, 1'b0);
        check("rst_dm_stall", dm_stall_o, 1'b0);
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_mem_we", mem_we_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_wdata", mem_wdata_o, 32'h0);
        check("rst_err", err_o, 1'b0);
        rst_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_mem_req", mem_req_o, 1'b0);
            check("idle_if_ack", if_ack_o, 1'b0);
        end

        // Tie after reset: DM write first, then IF; second tie goes to DM again
        run_scenario(1'b1, 32'h20, 1, 1'b1, 1'b1, 32'h10, 32'hCAFE_F00D, 0);
        run_scenario(1'b1, 32'h24, 0, 1'b1, 1'b0, 32'h10, 32'h0, 2);

        // IF read 0x4 with two wait cycles
        ref_mem[32'h4]  = 32'h2002_0005;
        phys_mem[32'h4] = 32'h2002_0005;
        run_scenario(1'b1, 32'h4, 2, 1'b0, 1'b0, 32'h0, 32'h0, 0);

        // Ready exactly at the watchdog limit: normal ack, no error
        run_scenario(1'b1, 32'h8, MAX_WAIT, 1'b0, 1'b0, 32'h0, 32'h0, 0);

        // Repeat fetch (buffer hit when enabled), then a DM write forces a refetch
        run_scenario(1'b1, 32'h8, 1, 1'b0, 1'b0, 32'h0, 32'h0, 0);
        run_scenario(1'b0, 32'h0, 0, 1'b1, 1'b1, 32'h30, 32'h1234_5678, 1);
        run_scenario(1'b1, 32'h8, 0, 1'b0, 1'b0, 32'h0, 32'h0, 0);

        // Hung memory: abort with DEAD_BEEF, sticky error
        run_scenario(1'b1, 32'h34, NEVER, 1'b0, 1'b0, 32'h0, 32'h0, 0);
        run_scenario(1'b0, 32'h0, 0, 1'b1, 1'b0, 32'h10, 32'h0, 1);

        // Randomized mix of single and simultaneous requests
        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = $urandom_range(0, 2);
            run_scenario(sel != 1, rnd_addr(), rnd_wait(), sel != 0, 1'($urandom_range(0, 1)),
                         rnd_addr(), $urandom, rnd_wait());
        end

        // Reset in the middle of a waiting fetch
        step();
        if_req_i = 1'b1; if_addr_i = 32'h40;
        wait_q.push_back(3);
        step();
        check("mid_mem_req_before", mem_req_o, 1'b1);
        step();
        #2 rst_i = 1'b0;
        #1;
        check("mid_mem_req_async", mem_req_o, 1'b0);
        check("mid_if_ack", if_ack_o, 1'b0);
        check("mid_err", err_o, 1'b0);
        if_req_i = 1'b0;
        step();
        model_reset();
        rst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_if_ack", if_ack_o, 1'b0);
            check("post_rst_mem_req", mem_req_o, 1'b0);
        end
        run_scenario(1'b1, 32'h44, 1, 1'b1, 1'b0, 32'h48, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Unified-memory arbiter for the 5-stage pipelined CPU. Shares one single-port, variable-latency memory between the IF-stage instruction fetch and the MEM-stage data access. Returns per-port acknowledges and stall signals to the pipeline registers. Includes a wait-state watchdog so that a hung memory cannot freeze the pipeline.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_WAIT, 15, watchdog limit in cycles of mem_ready_i low during an access (1..255)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request, held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address, stable while if_req_i
- if_rdata_o  out  DATA_W  fetched word, valid when if_ack_o
- if_ack_o  out  1  one-cycle fetch completion pulse
- if_stall_o  out  1  if_req_i & ~if_ack_o
- dm_req_i  in  1  data request, held until dm_ack_o
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_rdata_o  out  DATA_W  read word, valid when dm_ack_o
- dm_ack_o  out  1  one-cycle data completion pulse
- dm_stall_o  out  1  dm_req_i & ~dm_ack_o
- mem_req_o  out  1  memory request, held until mem_ready_i
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ready_i
- mem_ready_i  in  1  access complete this cycle
- err_o  out  1  sticky watchdog-timeout flag

## Operation
- FSM states: IDLE, IF_ACC, DM_ACC.
- IDLE:
  - A port is eligible if its req_i is high and its ack_o is not high this cycle. A requester seeing its ack presents its next request from the following cycle.
  - If both ports are eligible, grant the port not granted last. last_grant resets to IF, so DM wins the first tie.
  - With one port eligible, grant that port.
  - On grant, register the address, we and wdata onto the mem_* outputs, set mem_req_o=1, clear the wait counter, and go to IF_ACC or DM_ACC.
  - IF grants always drive mem_we_o=0.
- IF_ACC / DM_ACC:
  - Hold all mem_* outputs stable.
  - On mem_ready_i=1:
    - Drop mem_req_o.
    - Capture mem_rdata_i into the granted port's rdata_o (for a DM write, dm_rdata_o is 0).
    - Pulse that port's ack_o for one cycle.
    - Update last_grant and return to IDLE.
  - While mem_ready_i=0 the wait counter increments.
  - When the counter equals MAX_WAIT, abort the access:
    - Drop mem_req_o.
    - Set rdata_o to 32'hDEAD_BEEF and pulse ack_o.
    - Set err_o=1 and return to IDLE.
  - An aborted write is treated as not performed.
- Simultaneous events:
  - mem_ready_i in the same cycle the counter hits MAX_WAIT: ready wins, no error.
  - New requests during an access wait. Stall outputs remain asserted.
- rdata_o holds its last value between acks.
- err_o clears only on reset.

## Timing
- Reset (rst_i=0, asynchronous) forces:
  - state IDLE
  - all outputs 0 (if_stall_o/dm_stall_o follow their equations, so they are 0 only while the corresponding req_i is low)
  - last_grant = IF
  - counter 0
  - fetch buffer invalid
- Reset mid-access drops mem_req_o immediately, and no ack is produced.
- Latency: req_i seen in cycle 0 → mem_req_o high in cycle 1 → mem_ready_i in cycle 1+w → ack_o in cycle 2+w (minimum 2 cycles, with w=0).
- Abort timing: ack_o in cycle 2+MAX_WAIT.
- Acks are registered. Stall outputs are combinational from req_i and ack_o.

## Configuration
- MEMARB_FETCH_BUF_EN is a compile-time macro.
- Defined:
  - Adds a one-entry fetch buffer (valid, address, data), loaded on every successful IF access.
  - An IF grant whose address matches the valid buffer skips memory: mem_req_o stays 0, if_ack_o pulses in the next cycle with the buffered data, and the FSM stays in IDLE.
  - The buffer is invalidated at the grant of any DM write (any address), on an IF abort, and on reset.
- Undefined: every fetch accesses memory, and no buffer registers exist.

## Test plan
- Reset, then both ports idle → all outputs 0 and mem_req_o never asserted; assert rst_i low mid-access (IF_ACC, w=3) → mem_req_o falls asynchronously, no ack after release.
- IF read 0x0000_0004, memory ready after 2 wait cycles with data 0x2002_0005 → if_ack_o in cycle 4, if_rdata_o = 0x2002_0005, if_stall_o high in cycles 0–3.
- Both ports request in the same cycle after reset → DM granted first. DM write 0x10 ← 0xCAFE_F00D shows mem_we_o=1. IF is granted next, then a second tie grants DM (alternation).
- Memory never ready, MAX_WAIT=15 → ack in cycle 17 with rdata 0xDEAD_BEEF, err_o=1 and sticky. mem_ready_i exactly at the limit → normal ack, err_o=0.
- With MEMARB_FETCH_BUF_EN, fetch 0x8 twice → second ack after 1 cycle with no mem_req_o. Insert a DM write between the fetches → second fetch goes to memory.
